fir_filter_param: RTL and testbench

//  Parametrised, coefficient-programmable, signed N-tap direct-form FIR filter.

---
 rtl/fir_pkg.sv | 55 +++++
 rtl/fir_coef_bank.sv | 38 +++
 rtl/fir_filter_param.sv | 145 ++++++++++++++
 tb/tb_fir_filter_param.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared helpers for the parametrised FIR filter.
//   prod_w / acc_w  : datapath width helpers
//   default_coef    : reset coefficient (moving average, floor(2**frac / ntaps))
//   round_shift     : round-half-up arithmetic right shift
//   sat_clip        : clip to a signed data_w range, flags clipping
package fir_pkg;

    // Full-precision width of one sample x coefficient product.
    function automatic int unsigned prod_w(int unsigned data_w, int unsigned coef_w);
        return data_w + coef_w;
    endfunction

    // Accumulator width: one product plus growth for summing ntaps terms.
    function automatic int unsigned acc_w(int unsigned data_w, int unsigned coef_w,
                                          int unsigned ntaps);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Moving-average coefficient used after reset.
    function automatic int unsigned default_coef(int unsigned frac_bits, int unsigned ntaps);
        return (32'd1 << frac_bits) / ntaps;
    endfunction

    // Add half an LSB of the result, then shift with sign (floor), i.e. round half up.
    function automatic logic signed [63:0] round_shift(logic signed [63:0] acc,
                                                       int unsigned frac);
        logic signed [63:0] half;
        if (frac == 0) begin
            return acc;
        end
        half = 64'sd1 <<< (frac - 1);
        return (acc + half) >>> frac;
    endfunction

    // Clip to [-2**(data_w-1), 2**(data_w-1)-1]; sat reports whether clipping happened.
    function automatic logic signed [63:0] sat_clip(input  logic signed [63:0] v,
                                                    input  int unsigned        data_w,
                                                    output logic               sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_w - 1));
        sat = 1'b0;
        if (v > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (v < lo) begin
            sat = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: NTAPS signed coefficients with a single write port.
//   clk, reset_n : clock, async active-low reset (restores moving-average defaults)
//   we/addr/wdata: write strobe, tap index, coefficient value (addr >= NTAPS ignored)
//   coef         : all coefficients, coef[k] multiplies x[n-k]
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS     = 4,
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             we,
    input  logic [$clog2(NTAPS)-1:0]         addr,
    input  logic [COEF_W-1:0]                wdata,
    output logic [NTAPS-1:0][COEF_W-1:0]     coef
);

    localparam int unsigned ADDR_W = $clog2(NTAPS);
    localparam logic [COEF_W-1:0] COEF_RST = COEF_W'(default_coef(FRAC_BITS, NTAPS));

    // Writes land regardless of pipeline enable; out-of-range indices match no tap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                coef[k] <= COEF_RST;
            end
        end else if (we) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                if (addr == ADDR_W'(k)) begin
                    coef[k] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Signed N-tap direct-form FIR with runtime coefficients, valid/ready streaming,
// round-half-up + saturation and a 2-stage pipeline (products, then sum/round/clip).
//   clk, reset_n            : clock, async active-low reset
//   in_data/in_valid/in_ready : input sample stream (in_ready is combinational)
//   out_data/out_valid/out_ready/out_sat : output stream, out_sat flags clipping
//   coef_we/coef_addr/coef_wdata : coefficient write port
//   flush                   : sync clear of delay line and pipeline valids
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int unsigned NTAPS     = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned FRAC_BITS = 7
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sat,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]         coef_wdata,
    input  logic                      flush
);

    localparam int unsigned PROD_W = prod_w(DATA_W, COEF_W);
    localparam int unsigned ACC_W  = acc_w(DATA_W, COEF_W, NTAPS);

    logic                           en;
    logic                           accept;
    logic [NTAPS-1:0][COEF_W-1:0]   coef_q;
    logic signed [DATA_W-1:0]       hist_q [NTAPS-1];
    logic signed [DATA_W-1:0]       tap_c  [NTAPS];
    logic signed [PROD_W-1:0]       prod_c [NTAPS];
    logic signed [PROD_W-1:0]       prod_q [NTAPS];
    logic                           s1_valid;
    logic signed [ACC_W-1:0]        acc_c;
    logic signed [63:0]             rnd_c;
    logic signed [DATA_W-1:0]       y_c;
    logic                           sat_c;

    // Whole pipeline advances unless a valid output is being held by the sink.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en && !flush;

    fir_coef_bank #(
        .NTAPS     (NTAPS),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_coef_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (coef_we),
        .addr    (coef_addr),
        .wdata   (coef_wdata),
        .coef    (coef_q)
    );

    // Tap vector: incoming sample is x[n], the delay line supplies x[n-1..n-NTAPS+1].
    always_comb begin
        tap_c[0] = $signed(in_data);
        for (int k = 1; k < int'(NTAPS); k++) begin
            tap_c[k] = hist_q[k-1];
        end
        for (int k = 0; k < int'(NTAPS); k++) begin
            prod_c[k] = PROD_W'(tap_c[k]) * PROD_W'($signed(coef_q[k]));
        end
    end

    // Delay line only moves on an accepted sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < int'(NTAPS) - 1; k++) begin
                hist_q[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < int'(NTAPS) - 1; k++) begin
                hist_q[k] <= '0;
            end
        end else if (accept) begin
            hist_q[0] <= tap_c[0];
            for (int k = 1; k < int'(NTAPS) - 1; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
        end
    end

    // Stage 1: register products; coefficient writes on this edge are not yet visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            for (int k = 0; k < int'(NTAPS); k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (en) begin
                s1_valid <= accept;
            end
            if (en) begin
                for (int k = 0; k < int'(NTAPS); k++) begin
                    prod_q[k] <= prod_c[k];
                end
            end
        end
    end

    // Stage 2 combinational: sum, round half up, saturate.
    always_comb begin
        acc_c = '0;
        for (int k = 0; k < int'(NTAPS); k++) begin
            acc_c = acc_c + ACC_W'(prod_q[k]);
        end
        rnd_c = round_shift(64'(acc_c), FRAC_BITS);
        sat_c = 1'b0;
        y_c   = DATA_W'(sat_clip(rnd_c, DATA_W, sat_c));
    end

    // Stage 2 register: result only replaced when a valid stage-1 word moves forward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (en) begin
                out_valid <= s1_valid;
            end
            if (en && s1_valid) begin
                out_data <= y_c;
                out_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param: scoreboard driven by an arithmetic
// reference of the filter equation, plus directed checks of the documented cases.
module tb_fir_filter_param;

    localparam int NTAPS     = 4;
    localparam int DATA_W    = 16;
    localparam int COEF_W    = 8;
    localparam int FRAC_BITS = 7;
    localparam longint YMAX  = 32767;
    localparam longint YMIN  = -32768;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_sat;
    logic                     coef_we;
    logic [1:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     flush;

    always #5 clk = ~clk;

    fir_filter_param #(
        .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sat    (out_sat),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .flush      (flush)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int b [NTAPS];
    int hist [NTAPS-1];
    int exp_data_q [$];
    bit exp_sat_q [$];
    int got_q [$];
    bit got_sat_q [$];
    int cyc = 0;
    int first_acc_cyc;
    int first_val_cyc;
    int n_acc;
    int n_out;

    bit obs_valid;
    bit obs_ready;
    bit obs_sat;
    int obs_data;

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) b[k] = (1 << FRAC_BITS) / NTAPS;
        for (int k = 0; k < NTAPS - 1; k++) hist[k] = 0;
        exp_data_q.delete();
        exp_sat_q.delete();
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        flush      = 1'b0;
    endtask

    // One clock: sample outputs, score any output word, update the model, advance.
    task automatic cycle();
        longint s, num, den, y;
        int     x;
        bit     en, sat;
        #1;
        obs_valid = out_valid;
        obs_ready = in_ready;
        obs_sat   = out_sat;
        obs_data  = int'(out_data);
        en = !obs_valid || out_ready;
        n_checks++;
        if (obs_ready !== en) begin
            n_fail++;
            $display("FAIL in_ready cyc=%0d got=%0b exp=%0b", cyc, obs_ready, en);
        end
        if (obs_valid) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            n_checks++;
            if (exp_data_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_output cyc=%0d got=%0d exp=none", cyc, obs_data);
            end else begin
                if (obs_data !== exp_data_q[0] || obs_sat !== exp_sat_q[0]) begin
                    n_fail++;
                    $display("FAIL output cyc=%0d got=%0d/sat%0b exp=%0d/sat%0b",
                             cyc, obs_data, obs_sat, exp_data_q[0], exp_sat_q[0]);
                end
                if (out_ready) begin
                    got_q.push_back(obs_data);
                    got_sat_q.push_back(obs_sat);
                    void'(exp_data_q.pop_front());
                    void'(exp_sat_q.pop_front());
                    n_out++;
                end
            end
        end
        if (flush) begin
            exp_data_q.delete();
            exp_sat_q.delete();
            for (int k = 0; k < NTAPS - 1; k++) hist[k] = 0;
        end else if (in_valid && en) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            n_acc++;
            x = int'(in_data);
            s = longint'(x) * b[0];
            for (int k = 1; k < NTAPS; k++) s += longint'(hist[k-1]) * b[k];
            den = longint'(1) << FRAC_BITS;
            num = s + den / 2;
            y = num / den;
            if ((num % den) != 0 && num < 0) y--;
            sat = 1'b0;
            if (y > YMAX) begin y = YMAX; sat = 1'b1; end
            else if (y < YMIN) begin y = YMIN; sat = 1'b1; end
            exp_data_q.push_back(int'(y));
            exp_sat_q.push_back(sat);
            for (int k = NTAPS - 2; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = x;
        end
        // Write takes effect after this edge's products were formed.
        if (coef_we) b[coef_addr] = int'(coef_wdata);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        coef_we   = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_coef(int k, int v, bit with_flush);
        coef_we    = 1'b1;
        coef_addr  = 2'(k);
        coef_wdata = COEF_W'(v);
        flush      = with_flush;
        in_valid   = 1'b0;
        cycle();
        coef_we    = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat got=%0b exp=0", out_sat); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_default_avg();
        int exp_tab [5] = '{25, 50, 75, 100, 100};
        got_q.delete();
        first_acc_cyc = -1;
        first_val_cyc = -1;
        in_valid = 1'b1;
        in_data  = 16'sd100;
        for (int i = 0; i < 6; i++) cycle();
        drain(4);
        n_checks++;
        if (first_val_cyc - first_acc_cyc != 2) begin
            n_fail++;
            $display("FAIL latency got=%0d exp=2", first_val_cyc - first_acc_cyc);
        end
        n_checks++;
        if (got_q.size() != 6) begin
            n_fail++;
            $display("FAIL avg_count got=%0d exp=6", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_q[i] != exp_tab[i]) begin
                    n_fail++;
                    $display("FAIL avg_out[%0d] got=%0d exp=%0d", i, got_q[i], exp_tab[i]);
                end
            end
        end
    endtask

    task automatic test_impulse();
        int coefs [4]   = '{64, 32, 16, 8};
        int exp_tab [9] = '{500, 250, 125, 63, 0, -500, -250, -125, -62};
        for (int k = 0; k < NTAPS; k++) write_coef(k, coefs[k], k == 0);
        got_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = (i == 0) ? 16'sd1000 : 16'sd0;
            cycle();
        end
        drain(4);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = (i == 0) ? -16'sd1000 : 16'sd0;
            cycle();
        end
        drain(4);
        n_checks++;
        if (got_q.size() != 9) begin
            n_fail++;
            $display("FAIL impulse_count got=%0d exp=9", got_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (got_q[i] != exp_tab[i]) begin
                    n_fail++;
                    $display("FAIL impulse[%0d] got=%0d exp=%0d", i, got_q[i], exp_tab[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int last;
        for (int k = 0; k < NTAPS; k++) write_coef(k, 127, k == 0);
        got_q.delete();
        got_sat_q.delete();
        in_valid = 1'b1;
        in_data  = 16'sd32767;
        for (int i = 0; i < 6; i++) cycle();
        drain(4);
        last = got_q.size() - 1;
        n_checks++;
        if (last < 0 || got_q[last] != 32767 || got_sat_q[last] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_pos got=%0d/sat%0b exp=32767/sat1",
                     (last < 0) ? 0 : got_q[last], (last < 0) ? 1'b0 : got_sat_q[last]);
        end
        in_valid = 1'b1;
        in_data  = -16'sd32768;
        for (int i = 0; i < 6; i++) cycle();
        drain(4);
        last = got_q.size() - 1;
        n_checks++;
        if (last < 0 || got_q[last] != -32768 || got_sat_q[last] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_neg got=%0d/sat%0b exp=-32768/sat1",
                     (last < 0) ? 0 : got_q[last], (last < 0) ? 1'b0 : got_sat_q[last]);
        end
    endtask

    task automatic test_back_to_back();
        int stall_data;
        int acc0, out0;
        for (int k = 0; k < NTAPS; k++) write_coef(k, $urandom_range(0, 255) - 128, k == 0);
        acc0 = n_acc;
        out0 = n_out;
        stall_data = 0;
        for (int i = 0; i < 60; i++) begin
            in_data   = DATA_W'($urandom);
            in_valid  = (i >= 15 && i < 25) ? 1'b1 : ($urandom_range(0, 9) < 7);
            out_ready = (i >= 20 && i < 25) ? 1'b0 :
                        (i >= 15) ? 1'b1 : ($urandom_range(0, 3) != 0);
            cycle();
            if (i == 20) stall_data = obs_data;
            if (i >= 20 && i < 25) begin
                n_checks += 3;
                if (obs_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready i=%0d got=%0b exp=0", i, obs_ready);
                end
                if (obs_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_out_valid i=%0d got=%0b exp=1", i, obs_valid);
                end
                if (obs_data != stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold i=%0d got=%0d exp=%0d", i, obs_data, stall_data);
                end
            end
        end
        drain(5);
        n_checks += 2;
        if (n_acc - acc0 != n_out - out0) begin
            n_fail++;
            $display("FAIL bp_conservation got=%0d exp=%0d", n_out - out0, n_acc - acc0);
        end
        if (exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_leftover got=%0d exp=0", exp_data_q.size());
        end
    endtask

    task automatic test_coef_flush();
        int idx;
        for (int k = 0; k < NTAPS; k++) write_coef(k, 32, k == 0);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data    = DATA_W'($urandom_range(0, 4000));
            coef_we    = (i == 4);
            coef_addr  = 2'd0;
            coef_wdata = 8'sd127;
            cycle();
        end
        coef_we  = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'sd5000;
        cycle();
        idx      = got_q.size();
        flush    = 1'b0;
        in_data  = 16'sd200;
        cycle();
        drain(4);
        n_checks++;
        if (got_q.size() != idx + 1) begin
            n_fail++;
            $display("FAIL flush_count got=%0d exp=%0d", got_q.size(), idx + 1);
        end else begin
            n_checks++;
            if (got_q[idx] != 198) begin
                n_fail++;
                $display("FAIL flush_zero_hist got=%0d exp=198", got_q[idx]);
            end
        end
    endtask

    task automatic test_async_reset();
        int exp_tab [6] = '{25, 50, 75, 100, 100, 100};
        write_coef(1, 10, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'sd300;
        for (int i = 0; i < 4; i++) cycle();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid got=%0b exp=1", out_valid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("FAIL areset_data got=%0d exp=0", out_data); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready got=%0b exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 16'sd100;
        for (int i = 0; i < 6; i++) cycle();
        drain(4);
        n_checks++;
        if (got_q.size() != 6) begin
            n_fail++;
            $display("FAIL areset_count got=%0d exp=6", got_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_q[i] != exp_tab[i]) begin
                    n_fail++;
                    $display("FAIL areset_out[%0d] got=%0d exp=%0d", i, got_q[i], exp_tab[i]);
                end
            end
        end
    endtask

    initial begin
        n_acc = 0;
        n_out = 0;
        first_acc_cyc = -1;
        first_val_cyc = -1;
        test_reset();
        test_default_avg();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_coef_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
